load_store_unit: RTL and testbench

//  Memory stage of the RV32I core, directly downstream of the ALU. Takes the ALU

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage of the RV32I core. Accepts one load or store at
// a time from execute and runs it as a single req/ack bus transaction. Returns
// aligned, sign/zero-extended load data to writeback. Reports misaligned,
// illegal-op and bus-timeout faults.
//
// Ports
//   pll_1_200MHz, system_reset : core clock, async active-high reset
//   req_*, mem_read/mem_write, funct3, address, store_data, rd : request from execute
//   resp_*                     : one-cycle completion toward writeback
//   bus_*                      : req/ack data bus (word addressed, byte strobes)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pll_1_200MHz,
    input  logic        system_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        resp_valid,
    output logic        resp_reg_write,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;
    logic [4:0]       rd_q;
    logic             load_q;

    logic             is_load;
    logic             is_store;
    logic             illegal_op;
    logic             misaligned;
    logic [31:0]      wdata_c;
    logic [3:0]       wstrb_c;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             timeout_hit;

    // Request decode: fault classification and store lane placement.
    always_comb begin
        is_load    = mem_read & ~mem_write;
        is_store   = mem_write & ~mem_read;
        illegal_op = (mem_read == mem_write)
                   || (is_load && ((funct3 == 3'd3) || (funct3[2:1] == 2'b11)))
                   || (is_store && (funct3 >= 3'd3));
        // funct3[1:0] gives the access size for both signed and unsigned loads.
        misaligned = ((funct3[1:0] == 2'b01) && address[0])
                   || ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        wdata_c    = '0;
        wstrb_c    = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_c = {4{store_data[7:0]}};
                    wstrb_c = 4'b0001 << address[1:0];
                end
                2'b01: begin
                    wdata_c = {2{store_data[15:0]}};
                    wstrb_c = address[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_c = store_data;
                    wstrb_c = 4'b1111;
                end
            endcase
        end
    end

    // Load extract from the returned word using the captured lane and size.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    // Control FSM with registered bus and response outputs.
    always_ff @(posedge pll_1_200MHz or posedge system_reset) begin
        if (system_reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            funct3_q       <= '0;
            lane_q         <= '0;
            rd_q           <= '0;
            load_q         <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_reg_write <= 1'b0;
            resp_rd        <= '0;
            resp_data      <= '0;
            resp_fault     <= FAULT_OK;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_wstrb      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= funct3;
                        lane_q    <= address[1:0];
                        rd_q      <= rd;
                        load_q    <= is_load;
                        req_ready <= 1'b0;
                        if (illegal_op || misaligned) begin
                            // Faulting request responds without a bus cycle.
                            state_q        <= RESP;
                            resp_valid     <= 1'b1;
                            resp_reg_write <= 1'b0;
                            resp_rd        <= rd;
                            resp_data      <= '0;
                            resp_fault     <= illegal_op ? FAULT_ILLEGAL : FAULT_ALIGN;
                        end else begin
                            state_q   <= BUS;
                            cnt_q     <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {address[31:2], 2'b00};
                            bus_wdata <= wdata_c;
                            bus_wstrb <= wstrb_c;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack || timeout_hit) begin
                        state_q    <= RESP;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_wdata  <= '0;
                        bus_wstrb  <= '0;
                        resp_valid <= 1'b1;
                        resp_rd    <= rd_q;
                        // An ack on the timeout edge still completes normally.
                        if (bus_ack) begin
                            resp_fault     <= FAULT_OK;
                            resp_reg_write <= load_q;
                            resp_data      <= load_q ? ld_data : 32'd0;
                        end else begin
                            resp_fault     <= FAULT_TIMEOUT;
                            resp_reg_write <= 1'b0;
                            resp_data      <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q        <= IDLE;
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    resp_reg_write <= 1'b0;
                    resp_rd        <= '0;
                    resp_data      <= '0;
                    resp_fault     <= FAULT_OK;
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit with a short
// bus timeout so the timeout and ack-on-timeout-edge cases are reachable.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        system_reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        resp_valid;
    logic        resp_reg_write;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .pll_1_200MHz  (clk),
        .system_reset  (system_reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .address       (address),
        .store_data    (store_data),
        .rd            (rd),
        .resp_valid    (resp_valid),
        .resp_reg_write(resp_reg_write),
        .resp_rd       (resp_rd),
        .resp_data     (resp_data),
        .resp_fault    (resp_fault),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    typedef struct {
        logic        rdop;
        logic        wrop;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        int          wait_n;   // no-ack cycles before ack; >= 100 means never ack
        logic [31:0] rdata;
        int          ecyc;     // expected bus_req-high cycles; 0 = no bus cycle
        logic [31:0] ebaddr;
        logic [31:0] ewdata;
        logic [3:0]  ewstrb;
        logic        ewe;
        logic        erw;
        logic [31:0] edata;
        logic [1:0]  efault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdop, input logic wrop, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                                input int wn, input logic [31:0] rdat, input int ecyc,
                                input logic [31:0] eba, input logic [31:0] ewd, input logic [3:0] ews,
                                input logic ewe, input logic erw, input logic [31:0] ed,
                                input logic [1:0] ef);
        vec_t v;
        v.rdop = rdop;  v.wrop = wrop;  v.f3 = f3;   v.addr = a;    v.sdata = sd;
        v.rd = r;       v.wait_n = wn;  v.rdata = rdat; v.ecyc = ecyc;
        v.ebaddr = eba; v.ewdata = ewd; v.ewstrb = ews; v.ewe = ewe; v.erw = erw;
        v.edata = ed;   v.efault = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int    cyc;
        logic  stable;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({t, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        mem_read   = v.rdop;
        mem_write  = v.wrop;
        funct3     = v.f3;
        address    = v.addr;
        store_data = v.sdata;
        rd         = v.rd;
        @(negedge clk);
        // Scramble the request inputs to show only the accepted values matter.
        req_valid  = 1'b0;
        mem_read   = ~v.rdop;
        mem_write  = ~v.wrop;
        funct3     = 3'd7;
        address    = ~v.addr;
        store_data = ~v.sdata;
        rd         = ~v.rd;
        chk({t, "_ready_busy"}, 32'(req_ready), 32'd0);
        if (v.ecyc != 0) begin
            chk({t, "_bus_addr"}, bus_addr, v.ebaddr);
            chk({t, "_bus_we"}, 32'(bus_we), 32'(v.ewe));
            chk({t, "_bus_wstrb"}, 32'(bus_wstrb), 32'(v.ewstrb));
            if (v.ewe) chk({t, "_bus_wdata"}, bus_wdata, v.ewdata);
        end
        cyc    = 0;
        stable = 1'b1;
        while (bus_req && cyc < 20) begin
            cyc++;
            if (bus_addr !== v.ebaddr || bus_we !== v.ewe || bus_wstrb !== v.ewstrb ||
                (v.ewe && bus_wdata !== v.ewdata) || resp_valid !== 1'b0)
                stable = 1'b0;
            if (cyc == v.wait_n + 1) begin
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 32'h5A5A_C3C3;
            end
            @(negedge clk);
            bus_ack = 1'b0;
        end
        chk({t, "_bus_cycles"}, 32'(cyc), 32'(v.ecyc));
        if (v.ecyc != 0) chk({t, "_bus_stable"}, 32'(stable), 32'd1);
        chk({t, "_bus_req_off"}, 32'(bus_req), 32'd0);
        chk({t, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({t, "_resp_fault"}, 32'(resp_fault), 32'(v.efault));
        chk({t, "_resp_reg_write"}, 32'(resp_reg_write), 32'(v.erw));
        chk({t, "_resp_rd"}, 32'(resp_rd), 32'(v.rd));
        chk({t, "_resp_data"}, resp_data, v.edata);
        @(negedge clk);
        chk({t, "_resp_pulse"}, 32'(resp_valid), 32'd0);
        chk({t, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic saw_resp;
        system_reset = 1'b1;
        req_valid    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        funct3       = 3'd0;
        address      = '0;
        store_data   = '0;
        rd           = '0;
        bus_ack      = 1'b0;
        bus_rdata    = '0;

        //           rd wr f3    addr          sdata         rd wait rdata         cyc baddr         wdata         wstrb    we rw data          fault
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0100, 32'h0,        5, 3,   32'hDEAD_BEEF, 4, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'hDEAD_BEEF, 2'b00));
        vecs.push_back(mk(1, 0, 3'd0, 32'h0000_0103, 32'h0,        7, 0,   32'h80FF_FF7F, 1, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'hFFFF_FF80, 2'b00));
        vecs.push_back(mk(1, 0, 3'd4, 32'h0000_0103, 32'h0,        8, 1,   32'h80FF_FF7F, 2, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'h0000_0080, 2'b00));
        vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0102, 32'h0,        9, 0,   32'h80FF_FF7F, 1, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'hFFFF_80FF, 2'b00));
        vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0102, 32'h0,       10, 2,   32'h80FF_FF7F, 3, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'h0000_80FF, 2'b00));
        vecs.push_back(mk(1, 0, 3'd0, 32'h0000_0100, 32'h0,       11, 0,   32'h80FF_FF7F, 1, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'h0000_007F, 2'b00));
        vecs.push_back(mk(1, 0, 3'd0, 32'h0000_0102, 32'h0,       12, 0,   32'h80FF_FF7F, 1, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'hFFFF_FFFF, 2'b00));
        vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0100, 32'h0,       13, 0,   32'h1234_F00D, 1, 32'h0000_0100, 32'h0,        4'b0000, 0, 1, 32'hFFFF_F00D, 2'b00));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_010C, 32'h0,        0, 0,   32'h0000_0001, 1, 32'h0000_010C, 32'h0,        4'b0000, 0, 1, 32'h0000_0001, 2'b00));
        vecs.push_back(mk(0, 1, 3'd0, 32'h0000_0201, 32'h1234_5678, 3, 0,  32'h0,         1, 32'h0000_0200, 32'h7878_7878, 4'b0010, 1, 0, 32'h0,         2'b00));
        vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0202, 32'hCAFE_BABE, 4, 1,  32'h0,         2, 32'h0000_0200, 32'hBABE_BABE, 4'b1100, 1, 0, 32'h0,         2'b00));
        vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0200, 32'hCAFE_BABE, 4, 0,  32'h0,         1, 32'h0000_0200, 32'hBABE_BABE, 4'b0011, 1, 0, 32'h0,         2'b00));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0204, 32'hA5A5_1234, 6, 2,  32'h0,         3, 32'h0000_0204, 32'hA5A5_1234, 4'b1111, 1, 0, 32'h0,         2'b00));
        vecs.push_back(mk(0, 1, 3'd0, 32'h0000_0203, 32'h0000_00AB, 6, 3,  32'h0,         4, 32'h0000_0200, 32'hABAB_ABAB, 4'b1000, 1, 0, 32'h0,         2'b00));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0202, 32'h1111_1111, 1, 0,  32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b01));
        vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0101, 32'h0,        2, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b01));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0103, 32'h0,        3, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b01));
        vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0103, 32'h0,        4, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b01));
        vecs.push_back(mk(1, 0, 3'd3, 32'h0000_0100, 32'h0,        5, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(1, 1, 3'd2, 32'h0000_0100, 32'h0,        6, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0100, 32'h0,        7, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(0, 1, 3'd4, 32'h0000_0100, 32'h0,        8, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(0, 1, 3'd3, 32'h0000_0103, 32'h0,        9, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(1, 0, 3'd6, 32'h0000_0101, 32'h0,       10, 0,   32'h0,         0, 32'h0,         32'h0,        4'b0000, 0, 0, 32'h0,         2'b11));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0300, 32'h0,       11, 100, 32'h0,         4, 32'h0000_0300, 32'h0,        4'b0000, 0, 0, 32'h0,         2'b10));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0304, 32'h1122_3344, 12, 100, 32'h0,       4, 32'h0000_0304, 32'h1122_3344, 4'b1111, 1, 0, 32'h0,         2'b10));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        system_reset = 1'b0;

        foreach (vecs[i]) run(vecs[i], i);

        // Reset asserted mid-BUS: bus_req drops asynchronously, no response follows.
        @(negedge clk);
        req_valid = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = 3'd2;
        address   = 32'h0000_0400;
        rd        = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_bus_req_before", 32'(bus_req), 32'd1);
        #2 system_reset = 1'b1;
        #1;
        chk("mid_rst_bus_req_async", 32'(bus_req), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        system_reset = 1'b0;
        bus_ack      = 1'b1;
        bus_rdata    = 32'h0BAD_0BAD;
        saw_resp     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus_req !== 1'b0) saw_resp = 1'b1;
        end
        bus_ack = 1'b0;
        chk("mid_rst_no_resp", 32'(saw_resp), 32'd0);
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);

        // Unit recovers cleanly after the reset.
        run(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
